ram_multi_read_port_clr: RTL and testbench
==========================================

// Module: ram_multi_read_port_clr
// PURPOSE
//  Parametrised multi-read-port, single-write-port synchronous RAM (register file) for the pipelined datapath.
//  Generalises the dual-read-port RAM: N read ports, byte-enable writes, per-byte write-to-read forwarding,
//  and a sequential hardware clear engine. One write and READ_PORTS registered reads per cycle.
// PARAMETERS
//  DATA_WIDTH   16   word width in bits; must be a multiple of BYTE_WIDTH
//  ADDR_WIDTH   8    address width in bits
//  MEM_SIZE     256  number of words; must be <= 2**ADDR_WIDTH
//  READ_PORTS   2    number of independent read ports (>=1)
//  BYTE_WIDTH   8    bits per byte-enable lane; NB = DATA_WIDTH/BYTE_WIDTH lanes
//  CLEAR_VALUE  0    word written to every location by the clear engine
// PORTS
//  Clock          in   1                        rising-edge clock
//  Reset          in   1                        asynchronous, active-low reset
//  iWriteEnable   in   1                        write request
//  iWriteAddress  in   ADDR_WIDTH               write address
//  iByteEnable    in   NB                       per-lane write enable; lane k = bits [k*BYTE_WIDTH +: BYTE_WIDTH]
//  iDataIn        in   DATA_WIDTH               write data
//  iReadAddress   in   READ_PORTS*ADDR_WIDTH    packed read addresses; port p = [p*ADDR_WIDTH +: ADDR_WIDTH]
//  oDataOut       out  READ_PORTS*DATA_WIDTH    packed registered read data; port p = [p*DATA_WIDTH +: DATA_WIDTH]
//  iClearRequest  in   1                        start a full-memory clear (pulse, one cycle)
//  oClearBusy     out  1                        1 while the clear engine owns the memory
// BEHAVIOUR
//  Reset (Reset==0, async): oDataOut=0, FSM->CLEAR, clear counter=0, oClearBusy=1. Memory array not reset directly.
//  FSM states: CLEAR, IDLE.
//   CLEAR: each cycle writes CLEAR_VALUE to Ram[counter], counter++; after writing MEM_SIZE-1 -> IDLE next cycle.
//          Exactly MEM_SIZE cycles in CLEAR after reset release or request. oClearBusy=1 throughout.
//   IDLE : oClearBusy=0. iClearRequest==1 -> CLEAR next cycle, counter=0. Write accepted in the request cycle.
//   iClearRequest while in CLEAR: ignored (no restart).
//  Writes: only in IDLE. Ram[iWriteAddress] lane k <= iDataIn lane k when iWriteEnable && iByteEnable[k].
//   Writes in CLEAR silently dropped. iWriteAddress >= MEM_SIZE: write dropped.
//  Reads: latency 1 cycle, every port independent, every cycle.
//   IDLE: oDataOut[p] <= per-lane merge: lane k = iDataIn lane k if (iWriteEnable && iByteEnable[k] &&
//          iWriteAddress==iReadAddress[p] && address in range), else Ram[iReadAddress[p]] lane k (old contents).
//   CLEAR: oDataOut[p] <= CLEAR_VALUE for all ports regardless of address.
//   iReadAddress[p] >= MEM_SIZE: oDataOut[p] <= 0.
//  Multiple ports reading the same address (with or without forwarding) all get identical data.
//  iByteEnable==0 with iWriteEnable==1: no write, no forwarding (read returns stored word).
//  Reset asserted mid-clear or mid-write: all outputs to reset values immediately; clear restarts from 0 on release.
//  No X propagation: oDataOut never depends on an uninitialised word after the first clear completes.
// TESTING
//  T1 reset release -> oClearBusy=1 for exactly MEM_SIZE cycles (256), then 0; read any addr -> 0x0000 next cycle.
//  T2 IDLE write addr 0x05 data 0xBEEF BE=2'b11, port0 reads 0x05 same cycle -> oDataOut[0]=0xBEEF next cycle (forward).
//  T3 addr 0x05 holds 0xBEEF; write 0x1234 BE=2'b01 while ports 0,1 read 0x05 -> both 0xBE34; later read -> 0xBE34.
//  T4 READ_PORTS=4: ports read 0x00,0x01,0x05,0xFF with write to 0x01 data 0xAAAA BE=11 -> 0x0000,0xAAAA,stored,stored.
//  T5 iClearRequest with concurrent write 0x10<=0x5555; during CLEAR write 0x11<=0x7777 -> oDataOut=0 while busy;
//     after clear 0x10 and 0x11 both read 0x0000.
//  T6 MEM_SIZE=200: write addr 0xF0 dropped, read addr 0xF0 -> 0; Reset pulse at clear count 100 -> busy restarts, 200 cycles.

Source files
------------

// File: rtl/ram_multi_read_port_clr.sv
// Multi-read-port, single-write-port register file with byte-enable writes,
// per-lane write-to-read forwarding and a sequential clear engine.
module ram_multi_read_port_clr #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_SIZE   = 256,
  parameter int READ_PORTS = 2,
  parameter int BYTE_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic                             iWriteEnable,
  input  logic [ADDR_WIDTH-1:0]            iWriteAddress,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] iByteEnable,
  input  logic [DATA_WIDTH-1:0]            iDataIn,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] iReadAddress,
  output logic [READ_PORTS*DATA_WIDTH-1:0] oDataOut,
  input  logic                             iClearRequest,
  output logic                             oClearBusy
);

  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH:0]   MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

  typedef enum logic {
    CLEAR,
    IDLE
  } stateT;

  stateT                 state, nextState;
  logic [ADDR_WIDTH-1:0] clearCount, nextClearCount;
  logic                  writeAllowed;
  logic [DATA_WIDTH-1:0] ram [MEM_SIZE];
  logic [DATA_WIDTH-1:0] readWord [READ_PORTS];
  logic [DATA_WIDTH-1:0] dataReg [READ_PORTS];

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= CLEAR;
      clearCount <= '0;
    end else begin
      state      <= nextState;
      clearCount <= nextClearCount;
    end
  end

  // The clear engine sweeps every word once; requests arriving mid-sweep are ignored.
  always_comb begin
    nextState      = state;
    nextClearCount = clearCount;
    oClearBusy     = 1'b0;
    unique case (state)
      CLEAR: begin
        oClearBusy     = 1'b1;
        nextClearCount = clearCount + 1'b1;
        if (clearCount == LAST_ADDR) begin
          nextState      = IDLE;
          nextClearCount = '0;
        end
      end
      IDLE: begin
        if (iClearRequest) begin
          nextState      = CLEAR;
          nextClearCount = '0;
        end
      end
    endcase
  end

  assign writeAllowed = (state == IDLE) && iWriteEnable &&
                        ({1'b0, iWriteAddress} < MEM_LIMIT);

  always_ff @(posedge Clock) begin
    if (state == CLEAR) begin
      ram[clearCount] <= CLEAR_VALUE;
    end else if (writeAllowed) begin
      for (int k = 0; k < NB; k++) begin
        if (iByteEnable[k]) begin
          ram[iWriteAddress][k*BYTE_WIDTH +: BYTE_WIDTH] <= iDataIn[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Forwarding merges only the lanes being written so a partial write reads back coherently.
  always_comb begin
    logic [ADDR_WIDTH-1:0] addr;
    logic                  hit;
    logic [DATA_WIDTH-1:0] word;
    addr = '0;
    hit  = 1'b0;
    word = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      addr = iReadAddress[p*ADDR_WIDTH +: ADDR_WIDTH];
      hit  = writeAllowed && (iWriteAddress == addr);
      word = ram[addr];
      for (int k = 0; k < NB; k++) begin
        if (hit && iByteEnable[k]) begin
          word[k*BYTE_WIDTH +: BYTE_WIDTH] = iDataIn[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
      if (state == CLEAR) begin
        readWord[p] = CLEAR_VALUE;
      end else if ({1'b0, addr} >= MEM_LIMIT) begin
        readWord[p] = '0;
      end else begin
        readWord[p] = word;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int p = 0; p < READ_PORTS; p++) begin
        dataReg[p] <= '0;
      end
    end else begin
      for (int p = 0; p < READ_PORTS; p++) begin
        dataReg[p] <= readWord[p];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < READ_PORTS; p++) begin
      oDataOut[p*DATA_WIDTH +: DATA_WIDTH] = dataReg[p];
    end
  end

endmodule

// File: tb/tb_ram_multi_read_port_clr.sv
// Scoreboard bench for ram_multi_read_port_clr: four read ports, 200-word memory
// so that out-of-range addresses can be exercised on an 8-bit address bus.
module tb_ram_multi_read_port_clr;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int MS = 200;
  localparam int RP = 4;

  logic            Clock;
  logic            Reset;
  logic            writeEnable;
  logic [AW-1:0]   writeAddress;
  logic [1:0]      byteEnable;
  logic [DW-1:0]   dataIn;
  logic [RP*AW-1:0] readAddress;
  logic [RP*DW-1:0] dataOut;
  logic            clearRequest;
  logic            clearBusy;

  typedef struct {
    int          due;
    int          port;
    logic [15:0] data;
    string       name;
  } expectT;

  expectT scoreboard[$];
  expectT monItem;
  int     compared   = 0;
  int     mismatched = 0;
  int     cycleCount = 0;

  ram_multi_read_port_clr #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS),
    .READ_PORTS(RP), .BYTE_WIDTH(8), .CLEAR_VALUE(16'h0000)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .iWriteEnable(writeEnable), .iWriteAddress(writeAddress),
    .iByteEnable(byteEnable), .iDataIn(dataIn),
    .iReadAddress(readAddress), .oDataOut(dataOut),
    .iClearRequest(clearRequest), .oClearBusy(clearBusy)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
    end
  endtask

  // Monitor: registered outputs settle after each edge; pop everything due by now.
  always @(posedge Clock) begin
    cycleCount++;
    #1;
    while (scoreboard.size() > 0 && scoreboard[0].due <= cycleCount) begin
      monItem = scoreboard.pop_front();
      if (monItem.port < 0)
        checkOutput(monItem.name, {15'b0, clearBusy}, monItem.data);
      else
        checkOutput(monItem.name, dataOut[monItem.port*DW +: DW], monItem.data);
    end
  end

  // Ports packed as {p3,p2,p1,p0}; expectations are for the edge that follows.
  task automatic applyStimulus(input logic we, input logic [7:0] wa, input logic [1:0] be,
                               input logic [15:0] d, input logic [31:0] ra, input logic clr,
                               input logic [63:0] expData, input logic expBusy, input string name);
    expectT e;
    @(negedge Clock);
    writeEnable  = we;
    writeAddress = wa;
    byteEnable   = be;
    dataIn       = d;
    readAddress  = ra;
    clearRequest = clr;
    for (int p = 0; p < RP; p++) begin
      e.due  = cycleCount + 1;
      e.port = p;
      e.data = expData[p*16 +: 16];
      e.name = $sformatf("%s.port%0d", name, p);
      scoreboard.push_back(e);
    end
    e.due  = cycleCount + 1;
    e.port = -1;
    e.data = {15'b0, expBusy};
    e.name = {name, ".busy"};
    scoreboard.push_back(e);
  endtask

  // Counts edges until the clear engine lets go; the first counted edge is the next one.
  task automatic waitClearDone(input int expected, input string name);
    int n;
    n = 0;
    do begin
      @(posedge Clock);
      #2;
      n++;
      writeEnable  = 1'b0;
      clearRequest = 1'b0;
    end while (clearBusy && n < 1000);
    checkOutput(name, 16'(n), 16'(expected));
  endtask

  initial begin
    Reset        = 1'b0;
    writeEnable  = 1'b0;
    writeAddress = '0;
    byteEnable   = '0;
    dataIn       = '0;
    readAddress  = '0;
    clearRequest = 1'b0;
    repeat (3) @(negedge Clock);
    for (int p = 0; p < RP; p++)
      checkOutput($sformatf("resetData.port%0d", p), dataOut[p*DW +: DW], 16'h0000);
    checkOutput("resetBusy", {15'b0, clearBusy}, 16'h0001);

    Reset = 1'b1;
    waitClearDone(MS, "initClearCycles");

    applyStimulus(0, 8'h00, 2'b00, 16'h0000, {8'hC7, 8'h50, 8'h07, 8'h00}, 0,
                  {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 0, "clearedRead");
    applyStimulus(1, 8'h05, 2'b11, 16'hBEEF, {8'h05, 8'h00, 8'h06, 8'h05}, 0,
                  {16'hBEEF, 16'h0000, 16'h0000, 16'hBEEF}, 0, "fullForward");
    applyStimulus(1, 8'h05, 2'b01, 16'h1234, {8'h05, 8'h04, 8'h05, 8'h05}, 0,
                  {16'hBE34, 16'h0000, 16'hBE34, 16'hBE34}, 0, "laneForward");
    applyStimulus(0, 8'h00, 2'b00, 16'h0000, {8'h05, 8'h06, 8'h05, 8'h05}, 0,
                  {16'hBE34, 16'h0000, 16'hBE34, 16'hBE34}, 0, "laneStored");
    applyStimulus(1, 8'h01, 2'b11, 16'hAAAA, {8'hFF, 8'h05, 8'h01, 8'h00}, 0,
                  {16'h0000, 16'hBE34, 16'hAAAA, 16'h0000}, 0, "mixedPorts");
    applyStimulus(1, 8'h05, 2'b00, 16'hFFFF, {8'h00, 8'h01, 8'h05, 8'h05}, 0,
                  {16'h0000, 16'hAAAA, 16'hBE34, 16'hBE34}, 0, "noLaneWrite");
    applyStimulus(1, 8'hF0, 2'b11, 16'h9999, {8'hC7, 8'h01, 8'h05, 8'hF0}, 0,
                  {16'h0000, 16'hAAAA, 16'hBE34, 16'h0000}, 0, "rangeWrite");
    applyStimulus(1, 8'h01, 2'b10, 16'h12CD, {8'h05, 8'hF0, 8'h01, 8'h01}, 0,
                  {16'hBE34, 16'h0000, 16'h12AA, 16'h12AA}, 0, "highLane");
    applyStimulus(1, 8'hC7, 2'b11, 16'h4321, {8'hC8, 8'hC7, 8'h01, 8'hF0}, 0,
                  {16'h0000, 16'h4321, 16'h12AA, 16'h0000}, 0, "lastWord");
    applyStimulus(0, 8'h00, 2'b00, 16'h0000, {8'h01, 8'h05, 8'h00, 8'hC7}, 0,
                  {16'h12AA, 16'hBE34, 16'h0000, 16'h4321}, 0, "storedRead");
    applyStimulus(1, 8'h10, 2'b11, 16'h5555, {8'h01, 8'h00, 8'h05, 8'h10}, 1,
                  {16'h12AA, 16'h0000, 16'hBE34, 16'h5555}, 1, "clearRequest");
    applyStimulus(1, 8'h11, 2'b11, 16'h7777, {8'hFF, 8'h05, 8'h10, 8'h11}, 1,
                  {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 1, "duringClear");
    waitClearDone(MS, "requestClearCycles");
    applyStimulus(0, 8'h00, 2'b00, 16'h0000, {8'h01, 8'h05, 8'h11, 8'h10}, 0,
                  {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 0, "afterClear");
    applyStimulus(1, 8'h20, 2'b11, 16'h0F0F, {8'h00, 8'hC7, 8'h11, 8'h20}, 0,
                  {16'h0000, 16'h0000, 16'h0000, 16'h0F0F}, 0, "preReset");
    applyStimulus(0, 8'h00, 2'b00, 16'h0000, {8'h20, 8'h20, 8'h20, 8'h20}, 0,
                  {16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F}, 0, "sharedRead");

    @(negedge Clock);
    Reset = 1'b0;
    #1;
    for (int p = 0; p < RP; p++)
      checkOutput($sformatf("asyncResetData.port%0d", p), dataOut[p*DW +: DW], 16'h0000);
    checkOutput("asyncResetBusy", {15'b0, clearBusy}, 16'h0001);
    @(negedge Clock);
    Reset = 1'b1;
    waitClearDone(MS, "resetClearCycles");

    @(negedge Clock);
    clearRequest = 1'b1;
    @(negedge Clock);
    clearRequest = 1'b0;
    repeat (100) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    checkOutput("midClearResetBusy", {15'b0, clearBusy}, 16'h0001);
    @(negedge Clock);
    Reset = 1'b1;
    waitClearDone(MS, "midClearRestart");

    applyStimulus(0, 8'h00, 2'b00, 16'h0000, {8'hC7, 8'h01, 8'h05, 8'h20}, 0,
                  {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 0, "finalRead");

    repeat (3) @(negedge Clock);
    checkOutput("scoreboardDrained", 16'(scoreboard.size()), 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
